// File: rtl/bcd_ip_pkg.sv
// Shared definitions for the bcd_ip peripheral: register map, status bits,
// converter state encoding and the double-dabble digit adjust helper.
package bcd_ip_pkg;

    localparam int BIN_WIDTH  = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

    localparam logic [4:0] REG0_OFFS   = 5'h00;
    localparam logic [4:0] REG1_OFFS   = 5'h04;
    localparam logic [4:0] REG2_OFFS   = 5'h08;
    localparam logic [4:0] REG3_OFFS   = 5'h0C;
    localparam logic [4:0] BCD_OFFS    = 5'h10;
    localparam logic [4:0] STATUS_OFFS = 5'h14;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT
    } conv_state_e;

    // Add 3 to every digit >= 5 so the following left shift carries correctly.
    function automatic logic [BCD_WIDTH-1:0] dd_adjust(input logic [BCD_WIDTH-1:0] v);
        logic [BCD_WIDTH-1:0] r;
        r = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_ip_double_dabble.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-and-add-3).
// A start pulse in any state aborts the current run and reloads.
module bcd_double_dabble
    import bcd_ip_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd_out
);

    conv_state_e          state;
    logic [4:0]           cnt;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_WIDTH-1:0] scratch;
    logic [BCD_WIDTH-1:0] adj;

    assign adj = dd_adjust(scratch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CONV_IDLE;
            cnt     <= '0;
            bin_sr  <= '0;
            scratch <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else if (start) begin
            state <= CONV_LOAD;
        end else begin
            case (state)
                CONV_LOAD: begin
                    bin_sr  <= bin_in;
                    scratch <= '0;
                    cnt     <= '0;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    state   <= CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    // 16 shift cycles, then one extra cycle to publish the result
                    if (cnt == 5'(BIN_WIDTH)) begin
                        bcd_out <= scratch;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= CONV_IDLE;
                    end else begin
                        scratch <= {adj[BCD_WIDTH-2:0], bin_sr[BIN_WIDTH-1]};
                        bin_sr  <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
                        cnt     <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bcd_ip_s00_axi_slave.sv
// AXI4-Lite responder for bcd_ip: four RW registers, BCD result and status.
// Writing REG0 kicks the double-dabble converter.
module bcd_ip_s00_axi_slave
    import bcd_ip_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic                          aw_full, w_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [DW-1:0]                 w_data;
    logic [SW-1:0]                 w_strb;
    logic [DW-1:0]                 regs [4];
    logic                          awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]                 rdata, rd_word;
    logic                          aw_hs, w_hs, ar_hs, wr_fire, start;
    logic                          aw_full_nx, w_full_nx, bvalid_nx, rvalid_nx;
    logic                          busy, done;
    logic [BCD_WIDTH-1:0]          bcd;
    logic                          unused_ok;

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = 2'b00;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], aw_addr[1:0]};

    assign aw_hs   = S_AXI_AWVALID && awready;
    assign w_hs    = S_AXI_WVALID && wready;
    assign ar_hs   = S_AXI_ARVALID && arready;
    assign wr_fire = aw_full && w_full;
    assign start   = wr_fire && ({aw_addr[4:2], 2'b00} == REG0_OFFS) && (|w_strb);

    // Next-state of the handshake flags; READYs are derived from them so they
    // drop on the same edge a holding register fills or BVALID/RVALID rises.
    always_comb begin
        aw_full_nx = wr_fire ? 1'b0 : (aw_full || aw_hs);
        w_full_nx  = wr_fire ? 1'b0 : (w_full || w_hs);
        bvalid_nx  = wr_fire || (bvalid && !S_AXI_BREADY);
        rvalid_nx  = ar_hs || (rvalid && !S_AXI_RREADY);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            aw_full <= aw_full_nx;
            w_full  <= w_full_nx;
            bvalid  <= bvalid_nx;
            awready <= !aw_full_nx && !bvalid_nx;
            wready  <= !w_full_nx && !bvalid_nx;
            if (aw_hs) aw_addr <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            // Slots 0x00-0x0C are the only writable ones; others are dropped.
            if (wr_fire && !aw_addr[4]) begin
                for (int b = 0; b < SW; b++) begin
                    if (w_strb[b]) regs[aw_addr[3:2]][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case ({S_AXI_ARADDR[4:2], 2'b00})
            REG0_OFFS, REG1_OFFS, REG2_OFFS, REG3_OFFS: rd_word = regs[S_AXI_ARADDR[3:2]];
            BCD_OFFS:    rd_word[BCD_WIDTH-1:0] = bcd;
            STATUS_OFFS: begin
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_DONE_BIT] = done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid  <= 1'b0;
            arready <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid  <= rvalid_nx;
            arready <= !rvalid_nx;
            if (ar_hs) rdata <= rd_word;
        end
    end

    bcd_double_dabble u_dd (
        .clk    (S_AXI_ACLK),
        .rst_n  (S_AXI_ARESETN),
        .start  (start),
        .bin_in (regs[0][BIN_WIDTH-1:0]),
        .busy   (busy),
        .done   (done),
        .bcd_out(bcd)
    );

endmodule
